// File: rtl/controlador_acesso.sv
// Access transaction controller: checks a snapshotted permission vector,
// opens a timed grant window or rejects, and locks out after repeated misses.
module controlador_acesso #(
  parameter int GRANT_CYCLES = 4,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] recurso,
  input  logic [0:6] permissoes,
  output logic       grant,
  output logic       deny,
  output logic       locked,
  output logic       busy,
  output logic [3:0] fail_count
);

  localparam int TMAX = (GRANT_CYCLES > LOCK_CYCLES) ?
                        GRANT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, GRANT, DENY, LOCK
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [3:0]      fails_nx;
  logic [2:0]      snap_rec, snap_rec_nx;
  logic [0:6]      snap_perm, snap_perm_nx;
  logic [7:0]      perm_ext;
  logic            hit;

  // Index 7 maps to a hard zero so an invalid resource is always a miss
  always_comb begin
    perm_ext = '0;
    for (int i = 0; i < 7; i++) perm_ext[i] = snap_perm[i];
  end

  assign hit = perm_ext[snap_rec];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      fail_count <= '0;
      snap_rec   <= '0;
      snap_perm  <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      fail_count <= fails_nx;
      snap_rec   <= snap_rec_nx;
      snap_perm  <= snap_perm_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    fails_nx     = fail_count;
    snap_rec_nx  = snap_rec;
    snap_perm_nx = snap_perm;
    unique case (state)
      IDLE: begin
        if (req) begin
          snap_rec_nx  = recurso;
          snap_perm_nx = permissoes;
          state_nx     = CHECK;
        end
      end
      CHECK: begin
        if (hit) begin
          fails_nx = '0;
          timer_nx = TW'(GRANT_CYCLES);
          state_nx = GRANT;
        end else begin
          fails_nx = fail_count + 4'd1;
          if (fails_nx == 4'(MAX_FAILS)) begin
            timer_nx = TW'(LOCK_CYCLES);
            state_nx = LOCK;
          end else begin
            state_nx = DENY;
          end
        end
      end
      GRANT: begin
        if (timer == TW'(1)) state_nx = IDLE;
        else timer_nx = timer - TW'(1);
      end
      DENY: state_nx = IDLE;
      LOCK: begin
        if (timer == TW'(1)) begin
          fails_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Timer still holds its load value only during the first LOCK cycle
  assign grant  = (state == GRANT);
  assign locked = (state == LOCK);
  assign busy   = (state != IDLE);
  assign deny   = (state == DENY) ||
                  ((state == LOCK) && (timer == TW'(LOCK_CYCLES)));

endmodule
